// File: rtl/alu_multicycle.sv
// Registered ALU with single-cycle ops, multi-cycle shift-add MUL and optional restoring DIV.
// Define ALU_DIV_EN to build the divider for opcode 0xF; otherwise 0xF acts as NOP.
module alu_multicycle #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       alu_op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             negative_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHAMT_W:0] COUNT_INIT = (SHAMT_W+1)'(WIDTH);
  localparam logic [SHAMT_W:0] COUNT_LAST = (SHAMT_W+1)'(1);

  localparam logic [3:0] OP_ADD_DIRECT = 4'h1, OP_ADD_REG = 4'h2, OP_SUB = 4'h3,
                         OP_AND = 4'h4, OP_OR = 4'h5, OP_XOR = 4'h6, OP_NOT_A = 4'h7,
                         OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ROL = 4'hA, OP_ROR = 4'hB,
                         OP_CMP = 4'hC, OP_INC = 4'hD, OP_MUL = 4'hE, OP_DIV = 4'hF;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q;
  logic [SHAMT_W:0]   count_q;
  logic               isDiv_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [WIDTH-1:0]   result_q, resultHi_q;
  logic               zero_q, carry_q, negative_q, overflow_q, busy_q, done_q;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     addSum, subDiff, incSum, shlExt, shrExt;
  logic [WIDTH-1:0]   rolRes, rorRes;
  logic [WIDTH-1:0]   aluRes, flagSrc;
  logic               aluCarry, aluOverflow;
  logic               startMul, startDiv;

  assign shamt   = operand_b_i[SHAMT_W-1:0];
  assign addSum  = {1'b0, operand_a_i} + {1'b0, operand_b_i};
  assign subDiff = {1'b0, operand_a_i} - {1'b0, operand_b_i};
  assign incSum  = {1'b0, operand_a_i} + {{WIDTH{1'b0}}, 1'b1};
  // Extra bit on the shifted-out side captures the last bit lost.
  assign shlExt  = {1'b0, operand_a_i} << shamt;
  assign shrExt  = {operand_a_i, 1'b0} >> shamt;
  assign rolRes  = (operand_a_i << shamt) | (operand_a_i >> (WIDTH - int'(shamt)));
  assign rorRes  = (operand_a_i >> shamt) | (operand_a_i << (WIDTH - int'(shamt)));

  assign startMul = (alu_op_i == OP_MUL);
`ifdef ALU_DIV_EN
  assign startDiv = (alu_op_i == OP_DIV);
`else
  assign startDiv = 1'b0;
`endif

  always_comb begin
    aluRes      = '0;
    aluCarry    = 1'b0;
    aluOverflow = 1'b0;
    case (alu_op_i)
      OP_ADD_DIRECT, OP_ADD_REG: begin
        aluRes      = addSum[MSB:0];
        aluCarry    = addSum[WIDTH];
        aluOverflow = (operand_a_i[MSB] == operand_b_i[MSB]) && (addSum[MSB] != operand_a_i[MSB]);
      end
      OP_SUB, OP_CMP: begin
        aluRes      = (alu_op_i == OP_SUB) ? subDiff[MSB:0] : '0;
        aluCarry    = subDiff[WIDTH];
        aluOverflow = (operand_a_i[MSB] != operand_b_i[MSB]) && (subDiff[MSB] != operand_a_i[MSB]);
      end
      OP_AND:   aluRes = operand_a_i & operand_b_i;
      OP_OR:    aluRes = operand_a_i | operand_b_i;
      OP_XOR:   aluRes = operand_a_i ^ operand_b_i;
      OP_NOT_A: aluRes = ~operand_a_i;
      OP_SHL: begin
        aluRes   = shlExt[MSB:0];
        aluCarry = shlExt[WIDTH];
      end
      OP_SHR: begin
        aluRes   = shrExt[WIDTH:1];
        aluCarry = shrExt[0];
      end
      OP_ROL: begin
        aluRes   = rolRes;
        aluCarry = (shamt != '0) && rolRes[0];
      end
      OP_ROR: begin
        aluRes   = rorRes;
        aluCarry = (shamt != '0) && rorRes[MSB];
      end
      OP_INC: begin
        aluRes      = incSum[MSB:0];
        aluCarry    = incSum[WIDTH];
        aluOverflow = ~operand_a_i[MSB] & incSum[MSB];
      end
      default: aluRes = '0;
    endcase
    flagSrc = (alu_op_i == OP_CMP) ? subDiff[MSB:0] : aluRes;
  end

  // One iteration of the long op: hi_q/lo_q hold product halves for MUL, remainder/quotient for DIV.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] stepHi_d, stepLo_d;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divDiff;
`endif

  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    stepHi_d = mulSum[WIDTH:1];
    stepLo_d = {mulSum[0], lo_q[MSB:1]};
`ifdef ALU_DIV_EN
    divShift = {hi_q, lo_q[MSB]};
    divDiff  = divShift[MSB:0] - b_q;
    if (isDiv_q) begin
      if (divShift >= {1'b0, b_q}) begin
        stepHi_d = divDiff;
        stepLo_d = {lo_q[MSB-1:0], 1'b1};
      end else begin
        stepHi_d = divShift[MSB:0];
        stepLo_d = {lo_q[MSB-1:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      isDiv_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      resultHi_q  <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (startMul || startDiv) begin
              isDiv_q <= startDiv;
              a_q     <= operand_a_i;
              b_q     <= operand_b_i;
              hi_q    <= '0;
              lo_q    <= startDiv ? operand_a_i : operand_b_i;
              count_q <= COUNT_INIT;
              busy_q  <= 1'b1;
              state_q <= BUSY;
            end else begin
              result_q   <= aluRes;
              resultHi_q <= '0;
              zero_q     <= (flagSrc == '0);
              negative_q <= flagSrc[MSB];
              carry_q    <= aluCarry;
              overflow_q <= aluOverflow;
              done_q     <= 1'b1;
            end
          end
        end
        BUSY: begin
          hi_q    <= stepHi_d;
          lo_q    <= stepLo_d;
          count_q <= count_q - 1'b1;
          // The last step's values go straight to the outputs in the same edge.
          if (count_q == COUNT_LAST) begin
            result_q   <= stepLo_d;
            resultHi_q <= stepHi_d;
            zero_q     <= isDiv_q ? (stepLo_d == '0) : ({stepHi_d, stepLo_d} == '0);
            negative_q <= isDiv_q ? stepLo_d[MSB] : stepHi_d[MSB];
            carry_q    <= ~isDiv_q && (stepHi_d != '0);
            overflow_q <= isDiv_q && (b_q == '0);
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o    = result_q;
  assign result_hi_o = resultHi_q;
  assign zero_o      = zero_q;
  assign carry_o     = carry_q;
  assign negative_o  = negative_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and random bench for alu_multicycle (WIDTH=8) with a queue scoreboard of expected results.
// Expectations for opcode 0xF follow ALU_DIV_EN, matching the design build.
module tb_alu_multicycle;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] aluOp;
  logic [7:0] opA, opB;
  logic [7:0] result, resultHi;
  logic       zero, carry, negative, overflow, busy, done;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] flags;
    int         lat;
    int         driveCyc;
  } expT;

  expT sb[$];

  alu_multicycle #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .alu_op_i(aluOp),
    .operand_a_i(opA), .operand_b_i(opB),
    .result_o(result), .result_hi_o(resultHi),
    .zero_o(zero), .carry_o(carry), .negative_o(negative), .overflow_o(overflow),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic expT mkExp(input string tag, input logic [7:0] r, input logic [7:0] hi,
                                input logic [3:0] flags, input int lat);
    expT e;
    e.tag = tag; e.res = r; e.hi = hi; e.flags = flags; e.lat = lat; e.driveCyc = 0;
    return e;
  endfunction

  // Reference model, flags packed as {zero, carry, negative, overflow}.
  function automatic expT model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    expT e;
    int sa, sb2, s, n;
    logic [7:0] r;
    logic [15:0] p;
    logic c, v, zf, nf;
    sa = $signed(a); sb2 = $signed(b); n = int'(b[2:0]);
    r = 8'h00; c = 1'b0; v = 1'b0; p = 16'h0; s = 0;
    e.hi = 8'h00; e.lat = 1; e.driveCyc = 0;
    e.tag = $sformatf("rnd_op%0h_a%0h_b%0h", op, a, b);
    case (op)
      4'h1, 4'h2: begin s = a + b; r = s[7:0]; c = (s > 255); v = (sa + sb2 > 127) || (sa + sb2 < -128); end
      4'h3, 4'hC: begin
        s = a - b; r = (op == 4'h3) ? s[7:0] : 8'h00; c = (a < b);
        v = (sa - sb2 > 127) || (sa - sb2 < -128);
      end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: begin r = a; for (int i = 0; i < n; i++) begin c = r[7]; r = {r[6:0], 1'b0}; end end
      4'h9: begin r = a; for (int i = 0; i < n; i++) begin c = r[0]; r = {1'b0, r[7:1]}; end end
      4'hA: begin r = a; for (int i = 0; i < n; i++) r = {r[6:0], r[7]}; c = (n != 0) && r[0]; end
      4'hB: begin r = a; for (int i = 0; i < n; i++) r = {r[0], r[7:1]}; c = (n != 0) && r[7]; end
      4'hD: begin s = a + 1; r = s[7:0]; c = (a == 8'hFF); v = (a == 8'h7F); end
      4'hE: begin p = a * b; r = p[7:0]; e.hi = p[15:8]; c = (p[15:8] != 8'h00); e.lat = 9; end
`ifdef ALU_DIV_EN
      4'hF: begin
        e.lat = 9;
        if (b == 8'h00) begin r = 8'hFF; e.hi = a; v = 1'b1; end
        else begin r = a / b; e.hi = a % b; end
      end
`endif
      default: r = 8'h00;
    endcase
    zf = (r == 8'h00); nf = r[7];
    if (op == 4'hC) begin zf = (a == b); nf = s[7]; end
    if (op == 4'hE) begin zf = (p == 16'h0); nf = p[15]; end
    e.res = r;
    e.flags = {zf, c, nf, v};
    return e;
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input expT e);
    @(negedge clk);
    aluOp = op; opA = a; opB = b; start = 1'b1;
    e.driveCyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput();
    expT e;
    int waited;
    waited = 0;
    e = sb.pop_front();
    while (done !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("[TB] FAIL %s_timeout observed done=%b expected=1", e.tag, done);
    end
    compare({e.tag, "_latency"}, 16'(cyc - e.driveCyc), 16'(e.lat));
    compare({e.tag, "_result"}, {8'h00, result}, {8'h00, e.res});
    compare({e.tag, "_resultHi"}, {8'h00, resultHi}, {8'h00, e.hi});
    compare({e.tag, "_flagsZCNV"}, {12'h0, zero, carry, negative, overflow}, {12'h0, e.flags});
  endtask

  initial begin
    int doneSeen;
    logic [3:0] rop;
    logic [7:0] ra, rb;

    rst = 1'b1; start = 1'b0; aluOp = 4'h0; opA = 8'h00; opB = 8'h00;
    repeat (3) @(negedge clk);
    compare("reset_results", {result, resultHi}, 16'h0000);
    compare("reset_flags", {10'h0, zero, carry, negative, overflow, busy, done}, 16'h0000);
    rst = 1'b0;

    applyStimulus(4'h1, 8'h7F, 8'h01, mkExp("add_7f_01", 8'h80, 8'h00, 4'b0011, 1)); checkOutput();
    applyStimulus(4'h3, 8'h10, 8'h20, mkExp("sub_10_20", 8'hF0, 8'h00, 4'b0110, 1)); checkOutput();
    applyStimulus(4'hC, 8'h33, 8'h33, mkExp("cmp_33_33", 8'h00, 8'h00, 4'b1000, 1)); checkOutput();
    applyStimulus(4'h8, 8'hA1, 8'h03, mkExp("shl_a1_3", 8'h08, 8'h00, 4'b0100, 1)); checkOutput();
    applyStimulus(4'hB, 8'h01, 8'h01, mkExp("ror_01_1", 8'h80, 8'h00, 4'b0110, 1)); checkOutput();
    applyStimulus(4'h8, 8'h5C, 8'h00, mkExp("shl_5c_0", 8'h5C, 8'h00, 4'b0000, 1)); checkOutput();
    applyStimulus(4'hD, 8'h7F, 8'h00, mkExp("inc_7f", 8'h80, 8'h00, 4'b0011, 1)); checkOutput();
    applyStimulus(4'h0, 8'h12, 8'h34, mkExp("nop", 8'h00, 8'h00, 4'b1000, 1)); checkOutput();

    // MUL with a second start while busy that must be dropped.
    applyStimulus(4'hE, 8'hFF, 8'hFF, mkExp("mul_ff_ff", 8'h01, 8'hFE, 4'b0110, 9));
    compare("mul_busy_early", {15'h0, busy}, 16'h0001);
    @(negedge clk);
    aluOp = 4'h1; opA = 8'h01; opB = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compare("mul_busy_mid", {15'h0, busy}, 16'h0001);
    checkOutput();
    doneSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    compare("ignored_start_no_done", 16'(doneSeen), 16'h0000);
    compare("result_hold", {resultHi, result}, 16'hFE01);

`ifdef ALU_DIV_EN
    applyStimulus(4'hF, 8'd200, 8'd7, mkExp("div_200_7", 8'h1C, 8'h04, 4'b0000, 9)); checkOutput();
    applyStimulus(4'hF, 8'h5A, 8'h00, mkExp("div_5a_0", 8'hFF, 8'h5A, 4'b0011, 9)); checkOutput();
`else
    applyStimulus(4'hF, 8'h5A, 8'h00, mkExp("op_f_nop", 8'h00, 8'h00, 4'b1000, 1)); checkOutput();
`endif

    // Reset in the middle of a MUL aborts it.
    applyStimulus(4'hE, 8'h03, 8'h05, mkExp("mul_aborted", 8'h0F, 8'h00, 4'b0000, 9));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    compare("abort_results", {result, resultHi}, 16'h0000);
    compare("abort_flags", {10'h0, zero, carry, negative, overflow, busy, done}, 16'h0000);
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    compare("abort_no_done", 16'(doneSeen), 16'h0000);
    applyStimulus(4'h2, 8'h02, 8'h03, mkExp("add_after_abort", 8'h05, 8'h00, 4'b0000, 1)); checkOutput();

    for (int k = 0; k < 24; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(rop, ra, rb, model(rop, ra, rb));
      checkOutput();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
